// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC + imem req/ack, pre-decodes jumps, issues to decode one instr per 2 cycles at best.
// Redirect squashes and re-fetches via IDLE; decode stalls hold the output. Optional IFU_FETCH_COUNT_EN adds fetch_count.
module inst_fetch_unit #(
  parameter int                    PC_WIDTH    = 8,
  parameter int                    INSTR_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
  parameter logic [2:0]            JMP_OPCODE  = 3'b101
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ack,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [2:0]             opcode,
  output logic [PC_WIDTH-1:0]    pc_out,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc
`ifdef IFU_FETCH_COUNT_EN
  ,
  output logic [15:0]            fetch_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    r_pc_out;
  logic                   r_imem_req;
  logic                   r_instr_valid;
  logic [INSTR_WIDTH-1:0] r_instr_out;

  logic                   w_is_jmp;
  logic [PC_WIDTH-1:0]    w_next_pc;
  logic                   w_accept;

  // Jumps stay within the current 32-entry page: only the low 5 PC bits are replaced.
  assign w_is_jmp  = (imem_rdata[7:5] == JMP_OPCODE);
  assign w_next_pc = w_is_jmp ? {r_pc[PC_WIDTH-1:5], imem_rdata[4:0]}
                              : r_pc + PC_WIDTH'(1);
  assign w_accept  = (r_state == S_ISSUE) && r_instr_valid && instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr_out   <= '0;
      r_pc_out      <= '0;
    end else if (redirect_valid) begin
      // Redirect wins over any ack or decode handshake in the same cycle.
      r_state       <= S_IDLE;
      r_pc          <= redirect_pc;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_instr_out   <= imem_rdata;
            r_pc_out      <= r_pc;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_pc          <= w_next_pc;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= S_FETCH;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr_out   = r_instr_out;
  assign opcode      = r_instr_out[7:5];
  assign pc_out      = r_pc_out;

`ifdef IFU_FETCH_COUNT_EN
  logic [15:0] r_fetch_count;

  // Squashed handshakes (redirect in the same cycle) are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (!redirect_valid && w_accept && (r_fetch_count != 16'hFFFF)) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed vector table, hand-written corner sequences, then randomized traffic vs a program-order model.
module tb_inst_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_ack;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_out;
  logic [2:0] opcode;
  logic [7:0] pc_out;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
`ifdef IFU_FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ack       (imem_ack),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .opcode         (opcode),
    .pc_out         (pc_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFU_FETCH_COUNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 30) $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_next_pc(input logic [7:0] pc, input logic [7:0] ins);
    if (ins[7:5] == 3'b101) return {pc[7:5], ins[4:0]};
    return pc + 8'd1;
  endfunction

  typedef struct {
    logic [7:0] start_pc;
    logic [7:0] rdata;
    logic [2:0] exp_op;
    logic [7:0] exp_next;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = v.start_pc; imem_ack = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("vec_idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("vec_req", 32'(imem_req), 32'd1);
    chk("vec_addr", 32'(imem_addr), 32'(v.start_pc));
    imem_ack = 1'b1; imem_rdata = v.rdata;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("vec_valid", 32'(instr_valid), 32'd1);
    chk("vec_instr", 32'(instr_out), 32'(v.rdata));
    chk("vec_opcode", 32'(opcode), 32'(v.exp_op));
    chk("vec_pc_out", 32'(pc_out), 32'(v.start_pc));
    chk("vec_req_issue", 32'(imem_req), 32'd0);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("vec_req_next", 32'(imem_req), 32'd1);
    chk("vec_valid_next", 32'(instr_valid), 32'd0);
    chk("vec_next_addr", 32'(imem_addr), 32'(v.exp_next));
  endtask

  logic [7:0] mem[256];
  logic [7:0] exp_pc, exp_instr, exp_pcout, rd, rpc;
  logic       exp_vld, redir, ack, rdy;
  logic       prev_req, prev_ack, prev_redir;
  int         hs;
`ifdef IFU_FETCH_COUNT_EN
  logic [15:0] cnt0;
`endif

  initial begin
    vecs[0] = '{start_pc: 8'h23, rdata: 8'hAC, exp_op: 3'b101, exp_next: 8'h2C};
    vecs[1] = '{start_pc: 8'hFF, rdata: 8'h1F, exp_op: 3'b000, exp_next: 8'h00};
    vecs[2] = '{start_pc: 8'hFF, rdata: 8'hA3, exp_op: 3'b101, exp_next: 8'hE3};
    vecs[3] = '{start_pc: 8'h10, rdata: 8'hBF, exp_op: 3'b101, exp_next: 8'h1F};
    vecs[4] = '{start_pc: 8'h7F, rdata: 8'h60, exp_op: 3'b011, exp_next: 8'h80};
    vecs[5] = '{start_pc: 8'hE0, rdata: 8'hA0, exp_op: 3'b101, exp_next: 8'hE0};

    rst = 1'b1; imem_rdata = 8'h00; imem_ack = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 8'h00;

    // Reset state and first fetch from RESET_PC
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'd0);
    chk("rst_pc_out", 32'(pc_out), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
`ifdef IFU_FETCH_COUNT_EN
    chk("rst_count", 32'(fetch_count), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", 32'(imem_addr), 32'd0);
    imem_ack = 1'b1; imem_rdata = 8'h40; instr_ready = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_instr", 32'(instr_out), 32'h40);
    chk("t1_opcode", 32'(opcode), 32'd2);
    chk("t1_pc_out", 32'(pc_out), 32'd0);
    @(negedge clk);
    instr_ready = 1'b0;
    chk("t1_req_next", 32'(imem_req), 32'd1);
    chk("t1_next_addr", 32'(imem_addr), 32'h01);

    // Decode stall holds the issued instruction
    imem_ack = 1'b1; imem_rdata = 8'h2B;
    @(negedge clk);
    imem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t3_valid_hold", 32'(instr_valid), 32'd1);
      chk("t3_instr_hold", 32'(instr_out), 32'h2B);
      chk("t3_pc_hold", 32'(pc_out), 32'h01);
      chk("t3_req_low", 32'(imem_req), 32'd0);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("t3_req_after", 32'(imem_req), 32'd1);
    chk("t3_valid_after", 32'(instr_valid), 32'd0);
    chk("t3_addr_after", 32'(imem_addr), 32'h02);

    // Redirect coinciding with an ack discards the data
    imem_ack = 1'b1; imem_rdata = 8'hA5; redirect_valid = 1'b1; redirect_pc = 8'h80;
    @(negedge clk);
    imem_ack = 1'b0; redirect_valid = 1'b0;
    chk("t4_valid", 32'(instr_valid), 32'd0);
    chk("t4_idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", 32'(imem_addr), 32'h80);
    chk("t4_valid2", 32'(instr_valid), 32'd0);

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Reset while issuing clears the output registers asynchronously
    imem_ack = 1'b1; imem_rdata = 8'h77;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("t6_pre_valid", 32'(instr_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("t6_issue_valid", 32'(instr_valid), 32'd0);
    chk("t6_issue_instr", 32'(instr_out), 32'd0);
    chk("t6_issue_pc_out", 32'(pc_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_refetch_req", 32'(imem_req), 32'd1);

    // Reset while waiting for ack, with an ack arriving during and after reset
    #2 rst = 1'b1;
    #1;
    chk("t6_fetch_req", 32'(imem_req), 32'd0);
    chk("t6_fetch_addr", 32'(imem_addr), 32'd0);
    imem_ack = 1'b1; imem_rdata = 8'h55;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("t6_late_ack_valid", 32'(instr_valid), 32'd0);
    chk("t6_first_req", 32'(imem_req), 32'd1);
    chk("t6_first_addr", 32'(imem_addr), 32'd0);
`ifdef IFU_FETCH_COUNT_EN
    chk("t6_count0", 32'(fetch_count), 32'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      imem_ack = 1'b1; imem_rdata = 8'(k + 1);
      @(negedge clk);
      imem_ack = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
    end
    chk("t6_addr_after3", 32'(imem_addr), 32'd3);
`ifdef IFU_FETCH_COUNT_EN
    chk("t6_count3", 32'(fetch_count), 32'd3);
`endif

    // Randomized traffic against a program-order model
    for (int a = 0; a < 256; a++) begin
      mem[a] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) mem[a][7:5] = 3'b101;
    end
    exp_pc = 8'h00; exp_vld = 1'b0; exp_instr = 8'h00; exp_pcout = 8'h00;
    prev_req = 1'b0; prev_ack = 1'b0; prev_redir = 1'b1; hs = 0;
`ifdef IFU_FETCH_COUNT_EN
    cnt0 = 16'h0;
`endif
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (imem_req) chk("rand_addr", 32'(imem_addr), 32'(exp_pc));
        chk("rand_valid", 32'(instr_valid), 32'(exp_vld));
        if (exp_vld) begin
          chk("rand_instr", 32'(instr_out), 32'(exp_instr));
          chk("rand_pc_out", 32'(pc_out), 32'(exp_pcout));
          chk("rand_opcode", 32'(opcode), 32'(exp_instr[7:5]));
        end
        chk("rand_req_valid_excl", 32'(imem_req & instr_valid), 32'd0);
        if (prev_req && !prev_ack && !prev_redir) chk("rand_req_hold", 32'(imem_req), 32'd1);
      end else begin
`ifdef IFU_FETCH_COUNT_EN
        cnt0 = fetch_count;
`endif
      end
      redir = (i == 0) || ($urandom_range(0, 19) == 0);
      rpc   = 8'($urandom);
      ack   = ($urandom_range(0, 2) == 0);
      rd    = imem_req ? mem[imem_addr] : 8'($urandom);
      rdy   = 1'($urandom_range(0, 1));
      redirect_valid = redir; redirect_pc = rpc; imem_ack = ack; imem_rdata = rd; instr_ready = rdy;
      if (redir) begin
        exp_pc = rpc; exp_vld = 1'b0;
      end else if (imem_req && ack) begin
        exp_vld = 1'b1; exp_instr = rd; exp_pcout = exp_pc;
        exp_pc = model_next_pc(exp_pc, rd);
      end else if (exp_vld && rdy) begin
        exp_vld = 1'b0; hs++;
      end
      prev_req = imem_req; prev_ack = ack; prev_redir = redir;
    end
    @(negedge clk);
    redirect_valid = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    chk("rand_progress", 32'(hs >= 100), 32'd1);
`ifdef IFU_FETCH_COUNT_EN
    chk("rand_count", 32'(fetch_count), 32'(cnt0 + 16'(hs)));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage of the 8-bit processor; sits directly upstream of the opcode decoder/control unit.
- Holds the PC and fetches from instruction memory over a req/ack handshake.
- Presents each fetched instruction, its 3-bit opcode and its PC to decode over a valid/ready handshake.
- Pre-decodes unconditional jumps (opcode 101) and accepts redirects from execute.

Parameters:
- PC_WIDTH, 8, program counter / instruction address width (>= 6).
- INSTR_WIDTH, 8, instruction width; opcode = instr[7:5], jump target field = instr[4:0].
- RESET_PC, 0, PC value loaded on reset.
- JMP_OPCODE, 3'b101, opcode treated as unconditional jump by the pre-decoder.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  PC_WIDTH  fetch address; equals current PC.
- imem_rdata  input  INSTR_WIDTH  instruction data, valid with imem_ack.
- imem_ack  input  1  memory completes the fetch this cycle.
- instr_valid  output  1  instr_out/opcode/pc_out hold a valid instruction.
- instr_ready  input  1  decode accepts the instruction this cycle.
- instr_out  output  INSTR_WIDTH  registered fetched instruction.
- opcode  output  3  instr_out[7:5], fed to the control unit.
- pc_out  output  PC_WIDTH  address instr_out was fetched from.
- redirect_valid  input  1  execute-stage PC redirect (branch taken).
- redirect_pc  input  PC_WIDTH  redirect target.

Behaviour:
- Reset (async, rst=1): state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr_out=0, pc_out=0. All outputs registered except opcode (slice of instr_out) and imem_addr (=pc).
- States: IDLE, FETCH, ISSUE.
- IDLE:
  - imem_req=0.
  - Next edge goes to FETCH unconditionally.
  - imem_ack is ignored.
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until imem_ack.
  - On ack: instr_out<=imem_rdata, pc_out<=pc, instr_valid<=1, state<=ISSUE.
  - pc<= {pc[PC_WIDTH-1:5], imem_rdata[4:0]} if imem_rdata[7:5]==JMP_OPCODE, else pc+1 (modulo 2^PC_WIDTH; 0xFF wraps to 0x00).
- ISSUE:
  - imem_req=0.
  - instr_valid, instr_out and pc_out are held stable while instr_ready=0.
  - On instr_valid & instr_ready: instr_valid<=0, state<=FETCH.
- Latency:
  - ack at edge N gives instr_valid=1 after edge N.
  - Handshake at edge M gives imem_req=1 after edge M.
  - Zero-wait memory plus ready=1 gives one instruction per 2 cycles.
- Redirect (redirect_valid=1, any state): highest priority.
  - pc<=redirect_pc, instr_valid<=0 (squash), state<=IDLE.
  - An imem_ack in the same cycle is discarded: no instr_valid, no pc update from the data.
  - An instr_ready in the same cycle is irrelevant.
- imem_ack outside FETCH is ignored.
- Reset mid-operation clears all state immediately; a late ack after reset is ignored in IDLE.

Optional Feature:
- Macro: IFU_FETCH_COUNT_EN.
- Defined:
  - Adds output port fetch_count [15:0]: count of accepted decode handshakes (instr_valid & instr_ready).
  - Resets to 0 and saturates at 16'hFFFF.
  - Not cleared by redirect.
  - Squashed instructions are not counted.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Release reset, memory returns 0x40 at addr 0x00 with ack in first FETCH cycle, instr_ready=1 -> instr_out=0x40, opcode=3'b010, pc_out=0x00; next imem_addr=0x01.
2. pc=0x23, memory returns 0xAC (jmp, target 0x0C) -> pc_out=0x23; next imem_addr=0x2C.
3. Hold instr_ready=0 for 5 cycles after instr_valid -> instr_out, pc_out and instr_valid stable, imem_req=0 throughout; ready=1 gives imem_req=1 the next cycle.
4. redirect_valid=1, redirect_pc=0x80 in the same cycle as imem_ack -> no instr_valid, imem_req low for one cycle (IDLE), then imem_addr=0x80.
5. Non-jump fetch at pc=0xFF -> pc_out=0xFF; next imem_addr=0x00.
6. Assert rst while FETCH waits for ack, pulse imem_ack during reset -> imem_req/instr_valid drop immediately; after release the first fetch is at RESET_PC. With IFU_FETCH_COUNT_EN, fetch_count=0 after reset and 3 after three accepted instructions.
